mem_stage: RTL

//  Memory-access stage directly downstream of the execute stage. Registers EX

---
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory-access stage
// (master) and the data memory (slave).
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage. Forwards EX results to write-back and runs
// byte/half/word loads and stores over a req/ack data-memory bus, stalling
// upstream while an access is outstanding. A watchdog aborts accesses whose
// acknowledge never arrives.
module mem_stage #(
    parameter int TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  memop_i,
    input  logic [31:0] sdata_i,
    mem_stage_if.master mem,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_req_o,
    output logic        err_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LB  = 4'd1,
        OP_LH  = 4'd2,
        OP_LW  = 4'd3,
        OP_LBU = 4'd4,
        OP_LHU = 4'd5,
        OP_SB  = 4'd6,
        OP_SH  = 4'd7,
        OP_SW  = 4'd8
    } memop_t;

    // The counter holds (completed busy cycles - 1) at each BUSY edge, so the
    // edge that closes the 2**TIMEOUT_W-1'th busy cycle is the one at which it
    // would step to all-ones.
    localparam logic [TIMEOUT_W-1:0] WDOG_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_t               state_q, state_d;

    // Registered bus outputs
    logic                 req_q, req_d;
    logic                 we_q, we_d;
    logic [31:0]          addr_q, addr_d;
    logic [3:0]           sel_q, sel_d;
    logic [31:0]          mwdata_q, mwdata_d;

    // Access context held while BUSY
    memop_t               op_q, op_d;
    logic [1:0]           ea_q, ea_d;
    logic [4:0]           lwd_q, lwd_d;
    logic                 lwreg_q, lwreg_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;

    // Next values of the write-back outputs
    logic [4:0]           wd_d;
    logic                 wreg_d;
    logic [31:0]          wdata_d;
    logic                 err_d;

    // Decode of the incoming instruction
    logic                 is_load, is_store, is_byte, is_half, is_word;
    logic                 misaligned;
    logic [3:0]           sel_in;
    logic [31:0]          store_data;

    // Load lane extraction
    logic [31:0]          shifted;
    logic [31:0]          load_data;
    logic                 timeout;

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_sel   = sel_q;
    assign mem.mem_wdata = mwdata_q;

    // Stall comes from state only, so there is no path from mem_ack upstream.
    assign stall_req_o = (state_q == BUSY);
    assign timeout     = (wdog_q == WDOG_LAST);

    // Classify memop_i into load/store and access size; unused codes act as NOP.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, otherwise paths that skip an assignment infer a latch.
        is_load  = 1'b0;
        is_store = 1'b0;
        is_byte  = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (memop_i)
            OP_LB, OP_LBU: begin is_load  = 1'b1; is_byte = 1'b1; end
            OP_LH, OP_LHU: begin is_load  = 1'b1; is_half = 1'b1; end
            OP_LW:         begin is_load  = 1'b1; is_word = 1'b1; end
            OP_SB:         begin is_store = 1'b1; is_byte = 1'b1; end
            OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
            default:       ;
        endcase

        misaligned = (is_half && wdata_i[0]) || (is_word && (wdata_i[1:0] != 2'b00));

        if (is_byte) begin
            sel_in     = 4'b0001 << wdata_i[1:0];
            store_data = {4{sdata_i[7:0]}};
        end else if (is_half) begin
            sel_in     = 4'b0011 << wdata_i[1:0];
            store_data = {2{sdata_i[15:0]}};
        end else begin
            sel_in     = 4'b1111;
            store_data = sdata_i;
        end
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        shifted   = mem.mem_rdata >> {ea_q, 3'b000};
        load_data = mem.mem_rdata;
        case (op_q)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'h0, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data = {16'h0, shifted[15:0]};
            default: load_data = mem.mem_rdata;
        endcase
    end

    // Next-state and next-output logic for the IDLE/BUSY controller.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        mwdata_d = mwdata_q;
        op_d     = op_q;
        ea_d     = ea_q;
        lwd_d    = lwd_q;
        lwreg_d  = lwreg_q;
        wdog_d   = wdog_q;
        wd_d     = wd_o;
        wreg_d   = wreg_o;
        wdata_d  = wdata_o;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_load || is_store) begin
                    if (misaligned) begin
                        wreg_d = 1'b0;
                        err_d  = 1'b1;
                    end else begin
                        lwd_d    = wd_i;
                        lwreg_d  = wreg_i;
                        op_d     = memop_t'(memop_i);
                        ea_d     = wdata_i[1:0];
                        req_d    = 1'b1;
                        we_d     = is_store;
                        addr_d   = {wdata_i[31:2], 2'b00};
                        sel_d    = sel_in;
                        mwdata_d = store_data;
                        wreg_d   = 1'b0;
                        wdog_d   = '0;
                        state_d  = BUSY;
                    end
                end else begin
                    wd_d    = wd_i;
                    wreg_d  = wreg_i;
                    wdata_d = wdata_i;
                end
            end

            BUSY: begin
                wreg_d = 1'b0;
                wdog_d = wdog_q + WDOG_ONE;
                if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'b0000;
                    state_d = IDLE;
                    if (!we_q) begin
                        wd_d    = lwd_q;
                        wreg_d  = lwreg_q;
                        wdata_d = load_data;
                    end
                end else if (timeout) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'b0000;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Controller state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Datapath and output registers; reset clears everything so an access
    // in flight is abandoned without write-back or error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            sel_q    <= '0;
            mwdata_q <= '0;
            op_q     <= OP_NOP;
            ea_q     <= '0;
            lwd_q    <= '0;
            lwreg_q  <= 1'b0;
            wdog_q   <= '0;
            wd_o     <= '0;
            wreg_o   <= 1'b0;
            wdata_o  <= '0;
            err_o    <= 1'b0;
        end else begin
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            sel_q    <= sel_d;
            mwdata_q <= mwdata_d;
            op_q     <= op_d;
            ea_q     <= ea_d;
            lwd_q    <= lwd_d;
            lwreg_q  <= lwreg_d;
            wdog_q   <= wdog_d;
            wd_o     <= wd_d;
            wreg_o   <= wreg_d;
            wdata_o  <= wdata_d;
            err_o    <= err_d;
        end
    end

endmodule
